// File: rtl/clock_pkg.sv
// Shared time-of-day constants, HH:MM type and wrap/clamp helpers for the alarm clock.
// Pure combinational helpers with no state and no flow control.
package clock_pkg;

  localparam int HOURS_MAX = 23;
  localparam int MIN_MAX   = 59;
  localparam int SEC_MAX   = 59;
  localparam int HW        = 5;
  localparam int MW        = 6;

  typedef struct packed {
    logic [HW-1:0] hh;
    logic [MW-1:0] mm;
  } hhmm_t;

  function automatic logic [HW-1:0] clamp_hh(input logic [HW-1:0] h);
    return (h > HW'(HOURS_MAX)) ? HW'(HOURS_MAX) : h;
  endfunction

  function automatic logic [MW-1:0] clamp_mm(input logic [MW-1:0] m);
    return (m > MW'(MIN_MAX)) ? MW'(MIN_MAX) : m;
  endfunction

  // n is at most 59, so at most one hour carry and one midnight wrap can occur
  function automatic hhmm_t add_minutes(input logic [HW-1:0] hh, input logic [MW-1:0] mm,
                                        input logic [MW-1:0] n);
    hhmm_t r;
    int    m_sum;
    int    h_sum;
    m_sum = int'(mm) + int'(n);
    h_sum = int'(hh);
    if (m_sum > MIN_MAX) begin
      m_sum = m_sum - (MIN_MAX + 1);
      h_sum = h_sum + 1;
    end
    if (h_sum > HOURS_MAX) h_sum = 0;
    r.hh = HW'(h_sum);
    r.mm = MW'(m_sum);
    return r;
  endfunction

endpackage

// File: rtl/alarm_clock_multi_if.sv
// Control/status bundle of the multi-alarm clock: time load, alarm programming, snooze/dismiss, display outputs.
// Plain wires, no handshake; the slave side samples every input each clk.
interface alarm_clock_multi_if #(parameter int NUM_ALARMS = 4);
  import clock_pkg::*;

  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  time_set;
  logic [HW-1:0]         set_hours;
  logic [MW-1:0]         set_minutes;
  logic                  al_wr;
  logic [IW-1:0]         al_idx;
  logic [HW-1:0]         al_hours;
  logic [MW-1:0]         al_minutes;
  logic                  al_en;
  logic                  snooze;
  logic                  dismiss;
  logic [HW-1:0]         hours;
  logic [MW-1:0]         minutes;
  logic [MW-1:0]         seconds;
  logic                  tick;
  logic [NUM_ALARMS-1:0] ringing;
  logic                  alarm;

  modport master (
    output time_set, set_hours, set_minutes, al_wr, al_idx, al_hours, al_minutes, al_en,
           snooze, dismiss,
    input  hours, minutes, seconds, tick, ringing, alarm
  );

  modport slave (
    input  time_set, set_hours, set_minutes, al_wr, al_idx, al_hours, al_minutes, al_en,
           snooze, dismiss,
    output hours, minutes, seconds, tick, ringing, alarm
  );

endinterface

// File: rtl/alarm_channel.sv
// One alarm channel: programmed time, enable, snooze target and auto-dismissing ringing flag.
// Ringing is registered: set on the edge the clock reaches HH:MM:00; no backpressure.
module alarm_channel
  import clock_pkg::*;
#(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MAX_MIN = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [HW-1:0] cur_hh,
  input  logic [MW-1:0] cur_mm,
  input  logic [HW-1:0] nxt_hh,
  input  logic [MW-1:0] nxt_mm,
  input  logic [MW-1:0] nxt_ss,
  input  logic          tick,
  input  logic          min_roll,
  input  logic          wr,
  input  logic [HW-1:0] wr_hh,
  input  logic [MW-1:0] wr_mm,
  input  logic          wr_en,
  input  logic          snooze,
  input  logic          dismiss,
  output logic          ringing
);

  logic [HW-1:0] al_hh;
  logic [MW-1:0] al_mm;
  logic          en;
  logic          snz_vld;
  hhmm_t         snz;
  hhmm_t         snz_new;
  logic [5:0]    ring_cnt;
  logic          hit_al;
  logic          hit_snz;
  logic          match;

  assign hit_al  = (nxt_hh == al_hh) && (nxt_mm == al_mm);
  assign hit_snz = snz_vld && (nxt_hh == snz.hh) && (nxt_mm == snz.mm);
  assign match   = en && tick && (nxt_ss == '0) && (hit_al || hit_snz);
  assign snz_new = add_minutes(cur_hh, cur_mm, MW'(SNOOZE_MIN));

  // Priority: reprogramming, then a fresh match, then user/auto silencing of a ringing channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_hh    <= '0;
      al_mm    <= '0;
      en       <= 1'b0;
      snz_vld  <= 1'b0;
      snz      <= '0;
      ring_cnt <= '0;
      ringing  <= 1'b0;
    end else if (wr) begin
      al_hh    <= clamp_hh(wr_hh);
      al_mm    <= clamp_mm(wr_mm);
      en       <= wr_en;
      snz_vld  <= 1'b0;
      ring_cnt <= '0;
      ringing  <= 1'b0;
    end else if (match) begin
      ringing  <= 1'b1;
      ring_cnt <= '0;
    end else if (ringing) begin
      if (dismiss) begin
        ringing <= 1'b0;
        snz_vld <= 1'b0;
      end else if (snooze) begin
        ringing <= 1'b0;
        snz_vld <= 1'b1;
        snz     <= snz_new;
      end else if (min_roll) begin
        if (ring_cnt == 6'(RING_MAX_MIN - 1)) begin
          ringing <= 1'b0;
          snz_vld <= 1'b0;
        end else begin
          ring_cnt <= ring_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alarm_clock_multi.sv
// 24 h HH:MM:SS clock with prescaled tick and NUM_ALARMS alarm channels; time_set beats tick.
// Time, tick and ringing update on the same edge; inputs always accepted, no backpressure.
module alarm_clock_multi
  import clock_pkg::*;
#(
  parameter int TICK_DIV     = 1,
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MAX_MIN = 10
) (
  input logic                clk,
  input logic                rst_n,
  alarm_clock_multi_if.slave bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic [CW-1:0]         pre_cnt;
  logic                  tick_now;
  logic                  tick_q;
  logic                  min_roll;
  logic [HW-1:0]         hh_q;
  logic [HW-1:0]         nxt_hh;
  logic [MW-1:0]         mm_q;
  logic [MW-1:0]         nxt_mm;
  logic [MW-1:0]         ss_q;
  logic [MW-1:0]         nxt_ss;
  logic [NUM_ALARMS-1:0] ring_vec;

  // A time load restarts the second, so it also swallows any tick due this cycle
  assign tick_now = !bus.time_set && (pre_cnt == CW'(TICK_DIV - 1));

  always_comb begin
    nxt_ss   = ss_q + 1'b1;
    nxt_mm   = mm_q;
    nxt_hh   = hh_q;
    min_roll = 1'b0;
    if (ss_q == MW'(SEC_MAX)) begin
      nxt_ss   = '0;
      min_roll = tick_now;
      if (mm_q == MW'(MIN_MAX)) begin
        nxt_mm = '0;
        nxt_hh = (hh_q == HW'(HOURS_MAX)) ? '0 : hh_q + 1'b1;
      end else begin
        nxt_mm = mm_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
    end else begin
      tick_q <= tick_now;
      if (bus.time_set) begin
        pre_cnt <= '0;
        hh_q    <= clamp_hh(bus.set_hours);
        mm_q    <= clamp_mm(bus.set_minutes);
        ss_q    <= '0;
      end else if (tick_now) begin
        pre_cnt <= '0;
        hh_q    <= nxt_hh;
        mm_q    <= nxt_mm;
        ss_q    <= nxt_ss;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .SNOOZE_MIN  (SNOOZE_MIN),
      .RING_MAX_MIN(RING_MAX_MIN)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .cur_hh  (hh_q),
      .cur_mm  (mm_q),
      .nxt_hh  (nxt_hh),
      .nxt_mm  (nxt_mm),
      .nxt_ss  (nxt_ss),
      .tick    (tick_now),
      .min_roll(min_roll),
      .wr      (bus.al_wr && (bus.al_idx == IW'(i))),
      .wr_hh   (bus.al_hours),
      .wr_mm   (bus.al_minutes),
      .wr_en   (bus.al_en),
      .snooze  (bus.snooze),
      .dismiss (bus.dismiss),
      .ringing (ring_vec[i])
    );
  end

  assign bus.hours   = hh_q;
  assign bus.minutes = mm_q;
  assign bus.seconds = ss_q;
  assign bus.tick    = tick_q;
  assign bus.ringing = ring_vec;
  assign bus.alarm   = |ring_vec;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench: one clock with TICK_DIV=1 for time/alarm behaviour, one with TICK_DIV=4 for the prescaler.
module tb_alarm_clock_multi;

  logic clk = 1'b0;
  logic rst1_n;
  logic rst4_n;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alarm_clock_multi_if #(.NUM_ALARMS(4)) bus1 ();
  alarm_clock_multi_if #(.NUM_ALARMS(4)) bus4 ();

  alarm_clock_multi #(
    .TICK_DIV(1), .NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_MAX_MIN(10)
  ) dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));

  alarm_clock_multi #(
    .TICK_DIV(4), .NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_MAX_MIN(10)
  ) dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_time1(input string tag, input int h, input int m, input int s);
    check_val({tag, ".hh"}, 32'(bus1.hours), 32'(h));
    check_val({tag, ".mm"}, 32'(bus1.minutes), 32'(m));
    check_val({tag, ".ss"}, 32'(bus1.seconds), 32'(s));
  endtask

  task automatic set_time1(input logic [4:0] h, input logic [5:0] m);
    bus1.time_set    = 1'b1;
    bus1.set_hours   = h;
    bus1.set_minutes = m;
    step(1);
    bus1.time_set = 1'b0;
  endtask

  task automatic wr_al1(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m,
                        input logic en);
    bus1.al_wr      = 1'b1;
    bus1.al_idx     = idx;
    bus1.al_hours   = h;
    bus1.al_minutes = m;
    bus1.al_en      = en;
    step(1);
    bus1.al_wr = 1'b0;
  endtask

  task automatic pulse1(input logic snz, input logic dis);
    bus1.snooze  = snz;
    bus1.dismiss = dis;
    step(1);
    bus1.snooze  = 1'b0;
    bus1.dismiss = 1'b0;
  endtask

  initial begin
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    {bus1.time_set, bus1.set_hours, bus1.set_minutes, bus1.al_wr, bus1.al_idx} = '0;
    {bus1.al_hours, bus1.al_minutes, bus1.al_en, bus1.snooze, bus1.dismiss} = '0;
    {bus4.time_set, bus4.set_hours, bus4.set_minutes, bus4.al_wr, bus4.al_idx} = '0;
    {bus4.al_hours, bus4.al_minutes, bus4.al_en, bus4.snooze, bus4.dismiss} = '0;

    #12;
    check_time1("rst", 0, 0, 0);
    check_val("rst.tick", 32'(bus1.tick), 0);
    check_val("rst.ring", 32'(bus1.ringing), 0);
    check_val("rst.alarm", 32'(bus1.alarm), 0);
    check_val("rst4.tick", 32'(bus4.tick), 0);
    @(posedge clk);
    #1;
    rst1_n = 1'b1;

    // Clamped load lands on 23:59:00, then a full minute wraps everything to midnight
    set_time1(5'd31, 6'd63);
    check_time1("clamp", 23, 59, 0);
    check_val("set.tick", 32'(bus1.tick), 0);
    step(59);
    check_time1("pre_wrap", 23, 59, 59);
    step(1);
    check_time1("wrap", 0, 0, 0);
    check_val("wrap.tick", 32'(bus1.tick), 1);

    wr_al1(2'd0, 5'd6, 6'd30, 1'b1);
    set_time1(5'd6, 6'd29);
    step(59);
    check_val("basic.early", 32'(bus1.ringing), 0);
    step(1);
    check_time1("basic.t", 6, 30, 0);
    check_val("basic.ring", 32'(bus1.ringing), 32'b0001);
    check_val("basic.alarm", 32'(bus1.alarm), 1);
    step(1);
    check_val("basic.run.ss", 32'(bus1.seconds), 1);
    check_val("basic.still", 32'(bus1.ringing), 32'b0001);
    pulse1(1'b0, 1'b1);
    check_val("basic.dis", 32'(bus1.ringing), 0);
    check_val("basic.dis.alarm", 32'(bus1.alarm), 0);

    wr_al1(2'd0, 5'd6, 6'd30, 1'b0);
    wr_al1(2'd1, 5'd6, 6'd30, 1'b1);
    wr_al1(2'd2, 5'd6, 6'd31, 1'b1);
    wr_al1(2'd3, 5'd6, 6'd30, 1'b0);
    set_time1(5'd6, 6'd29);
    step(60);
    check_val("multi.0630", 32'(bus1.ringing), 32'b0010);
    step(60);
    check_val("multi.0631", 32'(bus1.ringing), 32'b0110);
    wr_al1(2'd1, 5'd6, 6'd30, 1'b0);
    check_val("multi.disable", 32'(bus1.ringing), 32'b0100);
    pulse1(1'b0, 1'b1);
    check_val("multi.dis", 32'(bus1.ringing), 0);

    // Snooze at 23:58:09 targets 00:03 across midnight
    wr_al1(2'd0, 5'd23, 6'd58, 1'b1);
    set_time1(5'd23, 6'd57);
    step(60);
    check_time1("snz.ring_t", 23, 58, 0);
    check_val("snz.ring", 32'(bus1.ringing), 32'b0001);
    step(9);
    pulse1(1'b1, 1'b0);
    check_val("snz.off", 32'(bus1.ringing), 0);
    check_val("snz.off.ss", 32'(bus1.seconds), 10);
    step(289);
    check_val("snz.early", 32'(bus1.ringing), 0);
    step(1);
    check_time1("snz.again_t", 0, 3, 0);
    check_val("snz.again", 32'(bus1.ringing), 32'b0001);
    pulse1(1'b0, 1'b1);
    check_val("snz.dis", 32'(bus1.ringing), 0);
    step(299);
    check_time1("snz.0008_t", 0, 8, 0);
    check_val("snz.0008", 32'(bus1.ringing), 0);

    set_time1(5'd23, 6'd57);
    step(60);
    check_val("both.ring", 32'(bus1.ringing), 32'b0001);
    pulse1(1'b1, 1'b1);
    check_val("both.off", 32'(bus1.ringing), 0);
    step(299);
    check_time1("both.0003_t", 0, 3, 0);
    check_val("both.no_rering", 32'(bus1.ringing), 0);

    // Dismiss on the matching edge loses; then the ring auto-clears ten minutes later
    set_time1(5'd23, 6'd57);
    step(59);
    pulse1(1'b0, 1'b1);
    check_val("match_wins", 32'(bus1.ringing), 32'b0001);
    step(599);
    check_val("auto.before", 32'(bus1.ringing), 32'b0001);
    step(1);
    check_time1("auto.t", 0, 8, 0);
    check_val("auto.off", 32'(bus1.ringing), 0);

    set_time1(5'd23, 6'd57);
    step(60);
    check_val("arst.ring", 32'(bus1.ringing), 32'b0001);
    #2;
    rst1_n = 1'b0;
    #1;
    check_time1("arst", 0, 0, 0);
    check_val("arst.tick", 32'(bus1.tick), 0);
    check_val("arst.ringing", 32'(bus1.ringing), 0);
    check_val("arst.alarm", 32'(bus1.alarm), 0);
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    step(1);
    check_time1("restart", 0, 0, 1);

    rst4_n = 1'b1;
    step(3);
    check_val("div4.t3.tick", 32'(bus4.tick), 0);
    check_val("div4.t3.ss", 32'(bus4.seconds), 0);
    step(1);
    check_val("div4.t4.tick", 32'(bus4.tick), 1);
    check_val("div4.t4.ss", 32'(bus4.seconds), 1);
    step(1);
    check_val("div4.t5.tick", 32'(bus4.tick), 0);
    step(3);
    check_val("div4.t8.tick", 32'(bus4.tick), 1);
    check_val("div4.t8.ss", 32'(bus4.seconds), 2);
    step(2);
    bus4.time_set    = 1'b1;
    bus4.set_hours   = 5'd10;
    bus4.set_minutes = 6'd20;
    step(1);
    bus4.time_set = 1'b0;
    check_val("div4.set.tick", 32'(bus4.tick), 0);
    check_val("div4.set.hh", 32'(bus4.hours), 10);
    check_val("div4.set.mm", 32'(bus4.minutes), 20);
    step(3);
    check_val("div4.set3.tick", 32'(bus4.tick), 0);
    check_val("div4.set3.ss", 32'(bus4.seconds), 0);
    step(1);
    check_val("div4.set4.tick", 32'(bus4.tick), 1);
    check_val("div4.set4.ss", 32'(bus4.seconds), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
